// File: rtl/menu_pkg.sv
// Shared types and helpers for the battle-menu controller: phase encoding,
// key codes, one-hot cursor rotation and one-hot to index conversion.
package menu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTRO = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } menu_phase_t;

  localparam logic [1:0] KEY_NONE   = 2'b00;
  localparam logic [1:0] KEY_RIGHT  = 2'b01;
  localparam logic [1:0] KEY_LEFT   = 2'b10;
  localparam logic [1:0] KEY_CANCEL = 2'b11;

  localparam int OH_MAX = 32;

  // Rotate a w-bit one-hot vector; to_lsb wraps bit 0 back to bit w-1.
  function automatic logic [OH_MAX-1:0] onehot_rot(input logic [OH_MAX-1:0] v,
                                                   input int w,
                                                   input logic to_lsb);
    logic [OH_MAX-1:0] keep;
    logic [OH_MAX-1:0] top;
    logic [OH_MAX-1:0] r;
    keep = (OH_MAX'(1) << w) - OH_MAX'(1);
    top  = OH_MAX'(1) << (w - 1);
    if (to_lsb) r = (v >> 1) | ((v[0]) ? top : '0);
    else        r = ((v << 1) & keep) | (((v & top) != '0) ? OH_MAX'(1) : '0);
    return r;
  endfunction

  // Index of the set bit, counting from the MSB of a w-bit vector as 0.
  function automatic int onehot_idx(input logic [OH_MAX-1:0] v, input int w);
    int idx;
    idx = 0;
    for (int i = 0; i < OH_MAX; i++) begin
      if (i < w && v[i]) idx = w - 1 - i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/menu_ctrl_text_reveal.sv
// Flavour-text reveal: frame counter plus saturating thermometer mask.
// One cycle from clear/tick/fill to mask; no backpressure, free-running while run is high.
module text_reveal #(
  parameter int TEXT_LEN      = 16,
  parameter int REVEAL_FRAMES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                run,
  input  logic                frame_tick,
  input  logic                fill,
  output logic [TEXT_LEN-1:0] mask
);

  localparam int FW = $clog2(REVEAL_FRAMES + 1);
  localparam logic [FW-1:0] LAST = FW'(REVEAL_FRAMES - 1);

  logic [FW-1:0]       cnt_q, cnt_d;
  logic [TEXT_LEN-1:0] mask_q, mask_d;

  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q;
    if (clear) begin
      cnt_d  = '0;
      mask_d = '0;
    end else if (run) begin
      if (frame_tick) begin
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          // Shifting in ones keeps an all-ones mask saturated.
          mask_d = (mask_q << 1) | TEXT_LEN'(1);
        end else begin
          cnt_d = cnt_q + FW'(1);
        end
      end
      if (fill) mask_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
    end
  end

  assign mask = mask_q;

endmodule

// File: rtl/menu_ctrl.sv
// Battle-menu control core: entry detect, cursor navigation, option sub-menu, result pulse.
// All outputs registered, one cycle after the sampled event; MENU_TEXT_SKIP_EN enables text skip.
module menu_ctrl
  import menu_pkg::*;
#(
  parameter int         N_CMD         = 4,
  parameter int         N_OPT         = 4,
  parameter int         TEXT_LEN      = 16,
  parameter int         REVEAL_FRAMES = 3,
  parameter logic [3:0] ENTRY_STATE   = 4'b0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [10:0]                hcount_in,
  input  logic [9:0]                 vcount_in,
  input  logic [3:0]                 state_in,
  input  logic [1:0]                 key_input_in,
  input  logic                       decide_in,
  output logic                       busy_out,
  output logic                       finished_out,
  output logic [1:0]                 phase_out,
  output logic [N_CMD-1:0]           selected_out,
  output logic [N_OPT-1:0]           opt_sel_out,
  output logic [TEXT_LEN-1:0]        reveal_out,
  output logic [$clog2(N_CMD)-1:0]   cmd_out,
  output logic [$clog2(N_OPT)-1:0]   opt_out
);

  localparam int CW = $clog2(N_CMD);
  localparam int OW = $clog2(N_OPT);
  localparam logic [N_CMD-1:0] SEL0 = N_CMD'(1) << (N_CMD - 1);
  localparam logic [N_OPT-1:0] OPT0 = N_OPT'(1) << (N_OPT - 1);

  menu_phase_t      phase_q, phase_d;
  logic [N_CMD-1:0] sel_q, sel_d;
  logic [N_OPT-1:0] opt_sel_q, opt_sel_d;
  logic [CW-1:0]    cmd_q, cmd_d;
  logic [OW-1:0]    opt_q, opt_d;
  logic             busy_q, busy_d;
  logic             fin_q, fin_d;
  logic [3:0]       prev_state_q, prev_state_d;
  logic [1:0]       prev_key_q, prev_key_d;
  logic             prev_dec_q, prev_dec_d;

  logic                entry, key_press, dec_rise, frame_tick, run, fill;
  logic [TEXT_LEN-1:0] reveal;

  assign entry      = (state_in == ENTRY_STATE) && (prev_state_q != ENTRY_STATE);
  assign key_press  = (prev_key_q == KEY_NONE) && (key_input_in != KEY_NONE);
  assign dec_rise   = decide_in && !prev_dec_q;
  assign frame_tick = (hcount_in == '0) && (vcount_in == '0);
  assign run        = (phase_q == INTRO) || (phase_q == SUB);

  always_comb begin
    phase_d      = phase_q;
    sel_d        = sel_q;
    opt_sel_d    = opt_sel_q;
    cmd_d        = cmd_q;
    opt_d        = opt_q;
    fill         = 1'b0;
    prev_state_d = state_in;
    prev_key_d   = key_input_in;
    prev_dec_d   = decide_in;

    // Entry wins over everything; decide wins over navigation in the same cycle.
    if (entry) begin
      phase_d = INTRO;
    end else begin
      unique case (phase_q)
        INTRO: begin
          if (dec_rise) begin
`ifdef MENU_TEXT_SKIP_EN
            if (!(&reveal)) begin
              fill = 1'b1;
            end else begin
              phase_d   = SUB;
              opt_sel_d = OPT0;
            end
`else
            phase_d   = SUB;
            opt_sel_d = OPT0;
`endif
          end else if (key_press) begin
            if (key_input_in == KEY_RIGHT)
              sel_d = N_CMD'(onehot_rot(OH_MAX'(sel_q), N_CMD, 1'b1));
            else if (key_input_in == KEY_LEFT)
              sel_d = N_CMD'(onehot_rot(OH_MAX'(sel_q), N_CMD, 1'b0));
          end
        end
        SUB: begin
          if (dec_rise) begin
            cmd_d   = CW'(onehot_idx(OH_MAX'(sel_q), N_CMD));
            opt_d   = OW'(onehot_idx(OH_MAX'(opt_sel_q), N_OPT));
            phase_d = DONE;
          end else if (key_press) begin
            if (key_input_in == KEY_RIGHT)
              opt_sel_d = N_OPT'(onehot_rot(OH_MAX'(opt_sel_q), N_OPT, 1'b1));
            else if (key_input_in == KEY_LEFT)
              opt_sel_d = N_OPT'(onehot_rot(OH_MAX'(opt_sel_q), N_OPT, 1'b0));
            else if (key_input_in == KEY_CANCEL)
              phase_d = INTRO;
          end
        end
        DONE:    phase_d = IDLE;
        default: phase_d = IDLE;
      endcase
    end

    busy_d = (phase_d == INTRO) || (phase_d == SUB);
    fin_d  = (phase_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= IDLE;
      sel_q        <= SEL0;
      opt_sel_q    <= OPT0;
      cmd_q        <= '0;
      opt_q        <= '0;
      busy_q       <= 1'b0;
      fin_q        <= 1'b0;
      prev_state_q <= ~ENTRY_STATE;
      prev_key_q   <= KEY_NONE;
      prev_dec_q   <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      sel_q        <= sel_d;
      opt_sel_q    <= opt_sel_d;
      cmd_q        <= cmd_d;
      opt_q        <= opt_d;
      busy_q       <= busy_d;
      fin_q        <= fin_d;
      prev_state_q <= prev_state_d;
      prev_key_q   <= prev_key_d;
      prev_dec_q   <= prev_dec_d;
    end
  end

  text_reveal #(
    .TEXT_LEN      (TEXT_LEN),
    .REVEAL_FRAMES (REVEAL_FRAMES)
  ) u_text_reveal (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (entry),
    .run        (run),
    .frame_tick (frame_tick),
    .fill       (fill),
    .mask       (reveal)
  );

  assign busy_out     = busy_q;
  assign finished_out = fin_q;
  assign phase_out    = phase_q;
  assign selected_out = sel_q;
  assign opt_sel_out  = opt_sel_q;
  assign reveal_out   = reveal;
  assign cmd_out      = cmd_q;
  assign opt_out      = opt_q;

endmodule
